// File: rtl/thread_sched.sv
// Round-robin scheduler for 32 hardware threads with a writeback-latency id pipe.
// Optional THREAD_SCHED_PRIO_EN adds a prio mask searched before the normal class.
module thread_sched #(
    parameter int          WB_LAT     = 2,
    parameter logic [31:0] RESET_MASK = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        wake,
    input  logic [4:0]  wake_id,
    input  logic        sleep,
    input  logic [4:0]  sleep_id,
`ifdef THREAD_SCHED_PRIO_EN
    input  logic [31:0] prio,
`endif
    output logic [4:0]  rthreadid,
    output logic        rvalid,
    output logic [4:0]  wthreadid,
    output logic        wvalid,
    output logic [31:0] runnable,
    output logic        idle
);

    logic [31:0] runnable_q;
    logic [31:0] runnable_d;
    logic [4:0]  last_q;
    logic [4:0]  id_q  [0:WB_LAT];
    logic        vld_q [0:WB_LAT];
    logic [31:0] inflight;
    logic [31:0] eligible;
    logic [5:0]  pick;
`ifdef THREAD_SCHED_PRIO_EN
    logic [5:0]  pick_prio;
`endif

    // Returns {found, id}: first set bit of req scanning last+1, last+2, ... modulo 32.
    function automatic logic [5:0] rr_pick(input logic [31:0] req, input logic [4:0] last);
        logic [5:0] res;
        logic [4:0] idx;
        res = '0;
        for (int i = 32; i >= 1; i--) begin
            idx = last + 5'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        // Wake is OR-ed in after the sleep clear so a same-id wake always survives.
        runnable_d = (runnable_q & ~(32'(sleep) << sleep_id)) | (32'(wake) << wake_id);
        inflight   = '0;
        for (int k = 0; k < WB_LAT; k++) begin
            if (vld_q[k]) inflight[id_q[k]] = 1'b1;
        end
        eligible = runnable_d & ~inflight;
        pick     = rr_pick(eligible, last_q);
`ifdef THREAD_SCHED_PRIO_EN
        pick_prio = rr_pick(eligible & prio, last_q);
        if (pick_prio[5]) pick = pick_prio;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runnable_q <= RESET_MASK;
            last_q     <= 5'd31;
            for (int k = 0; k <= WB_LAT; k++) begin
                id_q[k]  <= '0;
                vld_q[k] <= 1'b0;
            end
        end else begin
            runnable_q <= runnable_d;
            if (!stall) begin
                // An empty slot keeps the previous id so rthreadid only moves on real issues.
                if (pick[5]) begin
                    id_q[0]  <= pick[4:0];
                    vld_q[0] <= 1'b1;
                    last_q   <= pick[4:0];
                end else begin
                    vld_q[0] <= 1'b0;
                end
                for (int k = 0; k < WB_LAT; k++) begin
                    id_q[k+1]  <= id_q[k];
                    vld_q[k+1] <= vld_q[k];
                end
            end
        end
    end

    assign rthreadid = id_q[0];
    assign rvalid    = vld_q[0];
    assign wthreadid = id_q[WB_LAT];
    assign wvalid    = vld_q[WB_LAT];
    assign runnable  = runnable_q;
    assign idle      = (runnable_q == 32'd0);

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched (WB_LAT=2, RESET_MASK=1) with an expected-value queue.
module tb_thread_sched;

    localparam int W = 45;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        wake = 1'b0;
    logic [4:0]  wake_id = '0;
    logic        sleep = 1'b0;
    logic [4:0]  sleep_id = '0;
    logic [4:0]  rthreadid;
    logic        rvalid;
    logic [4:0]  wthreadid;
    logic        wvalid;
    logic [31:0] runnable;
    logic        idle;
`ifdef THREAD_SCHED_PRIO_EN
    logic [31:0] prio = '0;
`endif

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    thread_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .wake      (wake),
        .wake_id   (wake_id),
        .sleep     (sleep),
        .sleep_id  (sleep_id),
`ifdef THREAD_SCHED_PRIO_EN
        .prio      (prio),
`endif
        .rthreadid (rthreadid),
        .rvalid    (rvalid),
        .wthreadid (wthreadid),
        .wvalid    (wvalid),
        .runnable  (runnable),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [4:0] r, input logic rv, input logic [4:0] w,
                                        input logic wv, input logic [31:0] run);
        return {r, rv, w, wv, run, (run == 32'd0)};
    endfunction

    task automatic compare(input string nm, input logic [W-1:0] e);
        logic [W-1:0] a;
        a = {rthreadid, rvalid, wthreadid, wvalid, runnable, idle};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got r=%0d rv=%b w=%0d wv=%b run=%h idle=%b, expected r=%0d rv=%b w=%0d wv=%b run=%h idle=%b",
                     nm, a[44:40], a[39], a[38:34], a[33], a[32:1], a[0],
                     e[44:40], e[39], e[38:34], e[33], e[32:1], e[0]);
        end
    endtask

    // Monitor: every negedge, the outputs produced by the preceding posedge are checked.
    always @(negedge clk) begin
        if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
    end

    // Drives one cycle of inputs and queues the outputs expected after the next posedge.
    task automatic cyc(input logic st, input logic wk, input logic [4:0] wid, input logic sl,
                       input logic [4:0] sid, input logic [W-1:0] e, input string nm);
        stall    = st;
        wake     = wk;
        wake_id  = wid;
        sleep    = sl;
        sleep_id = sid;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        #2;
    endtask

    // Asynchronous reset between edges; outputs must clear immediately.
    task automatic do_reset(input string nm);
        stall = 1'b0;
        wake  = 1'b0;
        sleep = 1'b0;
        rst_n = 1'b0;
        #1;
        compare(nm, mk(5'd0, 1'b0, 5'd0, 1'b0, 32'h1));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #2;
        do_reset("reset_initial");

        // Single runnable thread: one issue every WB_LAT+1 cycles
        cyc(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 32'h1), "single_e1");
        cyc(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 32'h1), "single_e2");
        cyc(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 32'h1), "single_e3");
        cyc(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 32'h1), "single_e4");
        cyc(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 32'h1), "single_e5");
        cyc(0, 0, 0, 0, 0, mk(0, 0, 0, 1, 32'h1), "single_e6");
        do_reset("reset_after_single");

        // Wake 1,2,3 at reset release: full-rate round robin
        cyc(0, 1, 1, 0, 0, mk(0, 1, 0, 0, 32'h3), "rr4_e1");
        cyc(0, 1, 2, 0, 0, mk(1, 1, 0, 0, 32'h7), "rr4_e2");
        cyc(0, 1, 3, 0, 0, mk(2, 1, 0, 1, 32'hF), "rr4_e3");
        cyc(0, 0, 0, 0, 0, mk(3, 1, 1, 1, 32'hF), "rr4_e4");
        cyc(0, 0, 0, 0, 0, mk(0, 1, 2, 1, 32'hF), "rr4_e5");
        cyc(0, 0, 0, 0, 0, mk(1, 1, 3, 1, 32'hF), "rr4_e6");
        cyc(0, 0, 0, 0, 0, mk(2, 1, 0, 1, 32'hF), "rr4_e7");

        // Stall 3 cycles with a wake of 7 inside it
        cyc(1, 1, 7, 0, 0, mk(2, 1, 0, 1, 32'h8F), "stall_wake7");
        cyc(1, 0, 0, 0, 0, mk(2, 1, 0, 1, 32'h8F), "stall_hold2");
        cyc(1, 0, 0, 0, 0, mk(2, 1, 0, 1, 32'h8F), "stall_hold3");
        cyc(0, 0, 0, 0, 0, mk(3, 1, 1, 1, 32'h8F), "post_stall_e1");
        cyc(0, 0, 0, 0, 0, mk(7, 1, 2, 1, 32'h8F), "post_stall_e2");
        cyc(0, 0, 0, 0, 0, mk(0, 1, 3, 1, 32'h8F), "post_stall_e3");
        cyc(0, 0, 0, 0, 0, mk(1, 1, 7, 1, 32'h8F), "post_stall_e4");
        do_reset("reset_pipe_full");

        // Sleep at writeback; wake+sleep of same id
        cyc(0, 1, 1, 0, 0, mk(0, 1, 0, 0, 32'h3),  "sleep_e1");
        cyc(0, 0, 0, 0, 0, mk(1, 1, 0, 0, 32'h3),  "sleep_e2");
        cyc(0, 0, 0, 0, 0, mk(1, 0, 0, 1, 32'h3),  "sleep_e3");
        cyc(0, 0, 0, 0, 0, mk(0, 1, 1, 1, 32'h3),  "sleep_e4");
        cyc(0, 0, 0, 1, 1, mk(0, 0, 1, 0, 32'h1),  "sleep_at_wb");
        cyc(0, 1, 5, 1, 5, mk(5, 1, 0, 1, 32'h21), "wake_sleep_same");
        cyc(0, 0, 0, 0, 0, mk(0, 1, 0, 0, 32'h21), "sleep_e7");
        cyc(0, 0, 0, 0, 0, mk(0, 0, 5, 1, 32'h21), "sleep_e8");
        do_reset("reset_after_sleep");

        // Build runnable {0,30,31} with last=29, then check wrap-around order
        cyc(1, 0, 0,  1, 0,  mk(0,  0, 0,  0, 32'h0),         "wrap_sleep0");
        cyc(1, 1, 29, 0, 0,  mk(0,  0, 0,  0, 32'h2000_0000), "wrap_wake29");
        cyc(0, 0, 0,  0, 0,  mk(29, 1, 0,  0, 32'h2000_0000), "wrap_issue29");
        cyc(1, 1, 30, 1, 29, mk(29, 1, 0,  0, 32'h4000_0000), "wrap_wake30");
        cyc(1, 1, 31, 0, 0,  mk(29, 1, 0,  0, 32'hC000_0000), "wrap_wake31");
        cyc(1, 1, 0,  0, 0,  mk(29, 1, 0,  0, 32'hC000_0001), "wrap_wake0");
        cyc(0, 0, 0,  0, 0,  mk(30, 1, 0,  0, 32'hC000_0001), "wrap_e1");
        cyc(0, 0, 0,  0, 0,  mk(31, 1, 29, 1, 32'hC000_0001), "wrap_e2");
        cyc(0, 0, 0,  0, 0,  mk(0,  1, 30, 1, 32'hC000_0001), "wrap_e3");
        cyc(0, 0, 0,  0, 0,  mk(30, 1, 31, 1, 32'hC000_0001), "wrap_e4");

        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/thread_sched.md
# thread_sched

Round-robin hardware-thread scheduler for the 32-thread register file. Each cycle it picks the next runnable thread that has no instruction in flight and drives its id as the register-file read thread id. It delays that id through a writeback-latency pipe to produce the write thread id. It keeps the per-thread runnable mask, which is updated by channel wake events and instruction sleep events.

## Interface
Parameters:
- WB_LAT, 2: cycles from issue (rthreadid) to writeback (wthreadid); legal 1..4.
- RESET_MASK, 32'h0000_0001: runnable mask loaded at reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freezes issue and pipe; wake/sleep still processed.
- wake  in  1  set runnable bit wake_id.
- wake_id  in  5  thread to wake.
- sleep  in  1  clear runnable bit sleep_id.
- sleep_id  in  5  thread to sleep (normally wthreadid).
- rthreadid  out  5  issued thread id (register read select).
- rvalid  out  1  rthreadid holds a real issue.
- wthreadid  out  5  thread at writeback (register write select).
- wvalid  out  1  wthreadid valid; gates wea/web/wep/wepc upstream.
- runnable  out  32  current runnable mask.
- idle  out  1  runnable == 0.

## Operation
- State:
  - runnable[31:0].
  - last[4:0], the round-robin pointer.
  - Pipe stages s0..sWB_LAT, each holding (id, valid). s0 drives rthreadid/rvalid; sWB_LAT drives wthreadid/wvalid.
- Reset values: runnable=RESET_MASK, last=31, all stage ids 0 and valids 0, so rvalid=wvalid=0, rthreadid=wthreadid=0. idle = (RESET_MASK==0).
- Mask update every edge, stall or not: runnable_next = (runnable & ~(sleep<<sleep_id)) | (wake<<wake_id).
  - Wake and sleep on the same id in the same cycle: wake wins, so no wakeup is lost.
  - Wake and sleep on different ids both apply.
- inflight = OR of one-hot(id) over valid stages s0..s(WB_LAT-1). sWB_LAT is excluded because it writes back this edge.
- eligible = runnable_next & ~inflight. Eligibility uses runnable_next combinationally, so a thread put to sleep at writeback is never reissued on the same edge.
- Selection when !stall:
  - Pick the first eligible id searching last+1, last+2, … modulo 32.
  - If one is found: s0 ← (id,1) and last ← id.
  - If none is found: s0 ← (rthreadid,0) and last holds.
  - s(k+1) ← s(k) for every stage.
- When stall is high: all stages and last hold, and outputs stay constant.
- Sleeping a thread already in flight does not cancel it; the in-flight instruction still reaches writeback with wvalid=1.
- The same thread is reissued at most once every WB_LAT+1 cycles. Its register read therefore always follows its previous writeback.

## Timing
- Issue latency: an eligible thread appears on rthreadid one edge after the cycle it is selected.
- A wake in cycle t makes the thread selectable in cycle t (bypass); it reaches rthreadid at edge t+1.
- wthreadid = rthreadid delayed WB_LAT non-stalled edges; the valid travels with it.
- All outputs are registered except idle, which is decoded from the runnable register.
- Async reset takes effect immediately, mid-operation included. Any in-flight issues are discarded (wvalid drops to 0 with no writeback).
- Steady state with ≥ WB_LAT+1 runnable threads: rvalid=1 every non-stalled cycle.

## Configuration
- THREAD_SCHED_PRIO_EN defined:
  - Adds input prio [31:0] (quasi-static).
  - Selection first searches eligible & prio in round-robin order from last+1. Only if that set is empty does it search all eligible threads.
  - One shared last pointer serves both classes.
- Undefined: the prio port does not exist, and selection is pure round-robin as above.

## Test plan
- Reset defaults, WB_LAT=2, no stall → rthreadid=0 with rvalid pattern 1,0,0,1,0,0…; wthreadid=0 with wvalid=1 two edges after each issue.
- Wake 1,2,3 at reset release → rthreadid sequence 0,1,2,3,0,1… with rvalid=1 every cycle once all are runnable.
- Runnable {0,30,31} with last=29 → issue order 30,31,0,30 (wrap-around).
- sleep_id=wthreadid=1 while 1 is at writeback → 1 never reissued and runnable[1]=0. Wake and sleep of id 5 in the same cycle → runnable[5]=1.
- stall high for 3 cycles mid-stream → rthreadid, wthreadid and valids unchanged. A wake of 7 during the stall sets runnable[7]; 7 issues in round-robin order after the stall.
- Assert rst_n low between edges with the pipe full → rvalid=wvalid=0 and runnable=RESET_MASK immediately. With THREAD_SCHED_PRIO_EN, prio=1<<4 and runnable {0,4} (WB_LAT=1) → 4 issues every other cycle, and 0 only in the gaps.
